maze_solver_core: RTL

MAZE_SOLVER_CORE -- requirements
Module: maze_solver_core

---
 rtl/maze_solver_core_if.sv | 32 +++
 rtl/maze_solver_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_solver_core_if.sv
// maze_solver_core_if
//   Groups the maze-memory read port and the path-replay handshake of
//   maze_solver_core.
//   Parameter CW : coordinate width (maze address is 2*CW bits, {Y,X}).
//   Signals:
//     maze_re    solver -> memory  read strobe
//     maze_addr  solver -> memory  cell address {Y,X}
//     maze_rdata memory -> solver  1 = wall, valid one cycle after maze_re
//     move_valid solver -> sink    replayed move available
//     move_ready sink   -> solver  move accepted this cycle
//     move_dir   solver -> sink    replayed move direction
//   Modports: master (solver side), slave (memory / move sink side).
interface maze_solver_core_if #(
  parameter int CW = 4
);
  logic            maze_re;
  logic [2*CW-1:0] maze_addr;
  logic            maze_rdata;
  logic            move_valid;
  logic            move_ready;
  logic [1:0]      move_dir;

  modport master (
    output maze_re, maze_addr, move_valid, move_dir,
    input  maze_rdata, move_ready
  );

  modport slave (
    input  maze_re, maze_addr, move_valid, move_dir,
    output maze_rdata, move_ready
  );
endinterface

// File: rtl/maze_solver_core.sv
// maze_solver_core
//   Depth-first maze solver over a 2^CW x 2^CW grid. Starts at (0,0), probes
//   neighbours in direction order 0..3 (0:X-1, 1:Y+1, 2:Y-1, 3:X+1), pushes
//   every move on a 2-bit path stack, backtracks when a cell is exhausted and,
//   on reaching (2^CW-1, 2^CW-1), replays the stack bottom-up over a
//   valid/ready handshake.
//   Parameters: CW (coordinate width), DEPTH (path stack entries).
//   Ports:
//     clk        clock, all state changes on the rising edge
//     rst        asynchronous active-low reset
//     start      one-cycle solve request, honoured in IDLE/DONE/FAIL
//     bus        maze_solver_core_if.master (maze read port + replay handshake)
//     busy       solve or replay in progress
//     done       solve finished, path replayed
//     fail       no path found (or stack overflow)
//     overflow   the failure was a push on a full stack
//     X, Y       current cell
//     path_len   current stack occupancy
//   Optional feature: define MAZE_VISITED_EN to add a visited-cell map; a
//   visited neighbour is then treated as a wall. Without it only immediate
//   reversal is excluded, so cyclic mazes may end in overflow.
module maze_solver_core #(
  parameter int CW    = 4,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  maze_solver_core_if.master         bus,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic                       overflow,
  output logic [CW-1:0]              X,
  output logic [CW-1:0]              Y,
  output logic [$clog2(DEPTH+1)-1:0] path_len
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CMAX = '1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PROBE  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_BACK   = 3'd3;
  localparam logic [2:0] S_REPLAY = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

  logic [2:0]    state;
  logic [CW-1:0] x, y;
  logic [1:0]    dir;
  logic [PW-1:0] sp;
  logic [IW-1:0] ridx;
  logic          ovf;
  logic [1:0]    stack [DEPTH];

  logic [PW-1:0]   sp_m1;
  logic [1:0]      top;
  logic [2*CW-1:0] naddr;
  logic [2*CW-1:0] baddr;
  logic            oob;
  logic            skip;
  logic            full;
  logic            blocked;
  logic [2:0]      adv_state;

  // Cell reached from (cx,cy) by one step in direction d, packed as {Y,X}.
  function automatic logic [2*CW-1:0] step(input logic [CW-1:0] cx,
                                           input logic [CW-1:0] cy,
                                           input logic [1:0]    d);
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    sx = cx;
    sy = cy;
    unique case (d)
      2'd0:    sx = cx - CW'(1);
      2'd1:    sy = cy + CW'(1);
      2'd2:    sy = cy - CW'(1);
      default: sx = cx + CW'(1);
    endcase
    return {sy, sx};
  endfunction

  assign sp_m1 = sp - PW'(1);
  assign top   = stack[sp_m1[IW-1:0]];
  assign naddr = step(x, y, dir);
  // Direction codes are laid out so that bitwise inversion is the reverse move.
  assign baddr = step(x, y, ~top);
  assign full  = (sp == PW'(DEPTH));

  always_comb begin
    unique case (dir)
      2'd0:    oob = (x == '0);
      2'd1:    oob = (y == CMAX);
      2'd2:    oob = (y == '0);
      default: oob = (x == CMAX);
    endcase
  end

  // Out-of-bounds and straight-back-the-way-we-came are skipped without a read.
  assign skip = oob | ((sp != '0) & (dir == ~top));

  // Where to go when the current trial direction is rejected: next direction,
  // or, once all four are used up, backtrack (or give up at the start cell).
  assign adv_state = (dir != 2'd3) ? S_PROBE :
                     ((sp == '0) ? S_FAIL : S_BACK);

`ifdef MAZE_VISITED_EN
  logic [2**(2*CW)-1:0] visited;
  assign blocked = bus.maze_rdata | visited[naddr];
`else
  assign blocked = bus.maze_rdata;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
      dir   <= '0;
      sp    <= '0;
      ridx  <= '0;
      ovf   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
`ifdef MAZE_VISITED_EN
      visited <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state <= S_PROBE;
            x     <= '0;
            y     <= '0;
            dir   <= '0;
            sp    <= '0;
            ridx  <= '0;
            ovf   <= 1'b0;
`ifdef MAZE_VISITED_EN
            visited    <= '0;
            visited[0] <= 1'b1;
`endif
          end
        end

        S_PROBE: begin
          if (skip) begin
            dir   <= dir + 2'd1;
            state <= adv_state;
          end else begin
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (blocked) begin
            dir   <= dir + 2'd1;
            state <= adv_state;
          end else if (full) begin
            ovf   <= 1'b1;
            state <= S_FAIL;
          end else begin
            stack[sp[IW-1:0]] <= dir;
            sp    <= sp + PW'(1);
            {y, x} <= naddr;
            dir   <= '0;
            ridx  <= '0;
            state <= (naddr == '1) ? S_REPLAY : S_PROBE;
`ifdef MAZE_VISITED_EN
            visited[naddr] <= 1'b1;
`endif
          end
        end

        S_BACK: begin
          {y, x} <= baddr;
          sp     <= sp_m1;
          dir    <= top + 2'd1;
          // A popped 3 means that cell is exhausted too: keep unwinding.
          if (top == 2'd3) begin
            state <= (sp_m1 == '0) ? S_FAIL : S_BACK;
          end else begin
            state <= S_PROBE;
          end
        end

        S_REPLAY: begin
          if (bus.move_ready) begin
            if (ridx == sp_m1[IW-1:0]) begin
              state <= S_DONE;
            end else begin
              ridx <= ridx + IW'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.maze_re    = (state == S_PROBE) & ~skip;
  assign bus.maze_addr  = naddr;
  assign bus.move_valid = (state == S_REPLAY);
  assign bus.move_dir   = stack[ridx];

  assign busy     = (state == S_PROBE) | (state == S_CHECK) |
                    (state == S_BACK)  | (state == S_REPLAY);
  assign done     = (state == S_DONE);
  assign fail     = (state == S_FAIL);
  assign overflow = ovf;
  assign X        = x;
  assign Y        = y;
  assign path_len = sp;

endmodule
